load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_ADDR_W, 15, width of data-memory word address (memory is 2**MEM_ADDR_W 32-bit words).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- is_load  in  1  request is a load (`ENABLE level)
- is_store  in  1  request is a store (`ENABLE level)
- alucode  in  6  `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW from define.vh
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_data  out  32  load result, zero for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal request
- mem_req  out  1  memory access request
- mem_gnt  in  1  memory accepts the request this cycle
- mem_addr  out  MEM_ADDR_W  word address, addr[MEM_ADDR_W+1:2]
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_we  out  1  write strobe (store)
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  read word, valid the cycle after grant

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-005 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-006 SHALL latch alucode, addr, wdata and direction on acceptance; inputs are ignored at all other times.
REQ-007 SHALL flag an error on acceptance if: is_load and is_store both high; alucode inconsistent with direction; halfword at addr[1:0]=3; word at addr[1:0]!=0; addr[31:MEM_ADDR_W+2] nonzero.
REQ-008 SHALL ignore a cycle with req_valid high but neither is_load nor is_store high (stays IDLE, no response).
REQ-009 SHALL go IDLE->RESP on an erroring request, with resp_err=1, resp_data=0 and no memory request issued.
REQ-010 SHALL go IDLE->ISSUE on a legal request, holding mem_req=1 and stable mem_addr/mem_be/mem_we/mem_wdata until the cycle mem_gnt=1.
REQ-011 SHALL set mem_be per access size: byte 4'b0001<<addr[1:0]; halfword 4'b0011<<addr[1:0]; word 4'b1111.
REQ-012 SHALL drive mem_wdata with wdata[7:0] replicated to all lanes for SB, wdata[15:0] shifted left by 8*addr[1:0] for SH, and wdata for SW.
REQ-013 SHALL go ISSUE->RESP on grant for a store, and ISSUE->WAIT for a load.
REQ-014 SHALL in WAIT capture mem_rdata, extract the addressed byte/halfword at 8*addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU, pass LW unchanged, then go to RESP.
REQ-015 SHALL hold resp_valid=1 and resp_data/resp_err stable in RESP until resp_ready=1, then return to IDLE; no new request is accepted in that same cycle.
REQ-016 SHALL give latency from acceptance to resp_valid of: 1 cycle for errors; 2 cycles for a store with immediate grant; 3 cycles for a load with immediate grant; plus one cycle per cycle of mem_gnt=0.
REQ-017 SHALL keep mem_req=0 and mem_we=0 outside ISSUE; mem_we=1 only in ISSUE for stores.

Reset
REQ-018 SHALL on rst_n=0 at a clock edge enter IDLE and clear req_ready (goes to 1 the next cycle), resp_valid, resp_err, resp_data, mem_req, mem_we, mem_be and mem_wdata to 0 in any state, abandoning any in-flight access.
REQ-019 SHALL not issue a memory write after a reset asserted in the same cycle as a grant.

Verification
REQ-020 SHALL cover: SB addr=0x103, wdata=0xAB, immediate grant -> mem_addr=0x40, mem_be=4'b1000, mem_wdata=0xABABABAB, resp_valid at cycle 2, resp_err=0.
REQ-021 SHALL cover: LB addr=0x102 with mem_rdata=0x00F00000 -> resp_data=0xFFFFFFF0; the same access as LBU -> resp_data=0x000000F0; resp_valid at cycle 3.
REQ-022 SHALL cover: LW addr=0x6 -> resp_err=1 at cycle 1, mem_req never asserted; SH addr=0x7 -> same; LH addr=0x21 with mem_rdata=0x0080FF00 -> resp_data=0xFFFF80FF.
REQ-023 SHALL cover: SW addr=0x0002_0000 (MEM_ADDR_W=15) -> resp_err=1; SW addr=0x1FFFC with wdata=0x12345678 -> mem_addr=0x7FFF, mem_be=4'hF.
REQ-024 SHALL cover: mem_gnt held 0 for 3 cycles on a load -> mem_req stable, resp_valid at cycle 6; resp_ready held 0 for 2 cycles -> response stable, req_ready=0 throughout.
REQ-025 SHALL cover: rst_n=0 while in WAIT -> next cycle IDLE, all outputs 0, no response delivered; is_load and is_store both high -> resp_err=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, checks it, drives a
// single-word memory port with lane-aligned byte enables, and returns one response.
module load_store_unit #(
  parameter int MEM_ADDR_W = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [5:0]            alucode,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [5:0] ALU_LB  = 6'd18;
  localparam logic [5:0] ALU_LH  = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_LBU = 6'd21;
  localparam logic [5:0] ALU_LHU = 6'd22;
  localparam logic [5:0] ALU_SB  = 6'd23;
  localparam logic [5:0] ALU_SH  = 6'd24;
  localparam logic [5:0] ALU_SW  = 6'd25;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [5:0]            code;
    logic [MEM_ADDR_W+1:0] addr;
    logic [31:0]           wdata;
    logic                  store;
  } req_t;

  // Access size in bytes; 0 marks a code that is not a memory operation.
  function automatic logic [2:0] acc_size(input logic [5:0] c);
    case (c)
      ALU_LB, ALU_LBU, ALU_SB: acc_size = 3'd1;
      ALU_LH, ALU_LHU, ALU_SH: acc_size = 3'd2;
      ALU_LW, ALU_SW:          acc_size = 3'd4;
      default:                 acc_size = 3'd0;
    endcase
  endfunction

  state_t      state, state_n;
  req_t        req_q;
  logic        req_ready_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;

  logic        accept;
  logic        err_now;
  logic [2:0]  in_size;
  logic        in_ld_code, in_st_code;
  logic        align_err, range_err;

  always_comb begin
    in_size    = acc_size(alucode);
    in_ld_code = (alucode == ALU_LB) || (alucode == ALU_LH) || (alucode == ALU_LW) ||
                 (alucode == ALU_LBU) || (alucode == ALU_LHU);
    in_st_code = (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
    align_err  = ((in_size == 3'd2) && (addr[1:0] == 2'd3)) ||
                 ((in_size == 3'd4) && (addr[1:0] != 2'd0));
    range_err  = |(addr >> (MEM_ADDR_W + 2));
    err_now    = (is_load && is_store) || (is_load && !in_ld_code) ||
                 (is_store && !in_st_code) || align_err || range_err;
  end

  // A valid cycle with no direction is not a request at all.
  assign accept = req_valid && req_ready_q && (is_load || is_store);

  // Lane steering for the latched request.
  logic [1:0]  off;
  logic [2:0]  size_q;
  logic [3:0]  be;
  logic [31:0] wd_lane;
  logic [31:0] rshift;
  logic [31:0] ld_data;

  always_comb begin
    off    = req_q.addr[1:0];
    size_q = acc_size(req_q.code);
    case (size_q)
      3'd1:    be = 4'b0001 << off;
      3'd2:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    case (req_q.code)
      ALU_SB:  wd_lane = {4{req_q.wdata[7:0]}};
      ALU_SH:  wd_lane = {16'b0, req_q.wdata[15:0]} << {off, 3'b000};
      default: wd_lane = req_q.wdata;
    endcase
    rshift = mem_rdata >> {off, 3'b000};
    case (req_q.code)
      ALU_LB:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
      ALU_LH:  ld_data = {{16{rshift[15]}}, rshift[15:0]};
      ALU_LBU: ld_data = {24'b0, rshift[7:0]};
      ALU_LHU: ld_data = {16'b0, rshift[15:0]};
      default: ld_data = rshift;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = err_now ? RESP : ISSUE;
      ISSUE:   if (mem_gnt) state_n = req_q.store ? RESP : WAIT;
      WAIT:    state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state       <= state_n;
      req_ready_q <= (state_n == IDLE);
      if (accept) begin
        req_q.code  <= alucode;
        req_q.addr  <= addr[MEM_ADDR_W+1:0];
        req_q.wdata <= wdata;
        req_q.store <= is_store;
        resp_err_q  <= err_now;
        resp_data_q <= '0;
      end
      if (state == WAIT) resp_data_q <= ld_data;
    end
  end

  logic issue;
  assign issue = (state == ISSUE);

  assign req_ready  = req_ready_q;
  assign resp_valid = (state == RESP);
  assign resp_data  = resp_valid ? resp_data_q : '0;
  assign resp_err   = resp_valid & resp_err_q;

  // Gating with rst_n keeps a grant coinciding with reset from committing a write.
  assign mem_req   = issue & rst_n;
  assign mem_we    = issue & rst_n & req_q.store;
  assign mem_addr  = issue ? req_q.addr[MEM_ADDR_W+1:2] : '0;
  assign mem_be    = issue ? be : 4'b0000;
  assign mem_wdata = issue ? wd_lane : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, randomized transactions against a
// byte-level reference model, and hand sequences for reset corner cases.
module tb_load_store_unit;
  localparam int AW = 15;
  localparam logic [5:0] LB = 6'd18, LH = 6'd19, LW = 6'd20, LBU = 6'd21, LHU = 6'd22,
                         SB = 6'd23, SH = 6'd24, SW = 6'd25;

  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, is_load = 0, is_store = 0;
  logic [5:0] alucode = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_data;
  logic mem_req, mem_gnt = 0, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata, mem_rdata = 0;

  int n_vec = 0, n_bad = 0;

  load_store_unit #(.MEM_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .alucode(alucode), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  typedef struct {
    bit ld, st;
    logic [5:0] code;
    logic [31:0] addr, wdata, rdata;
    int gd, rd;
    bit err;
    logic [31:0] maddr;
    logic [3:0] be;
    logic [31:0] mwdata, data;
    int lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit ld, bit st, logic [5:0] code, logic [31:0] a, logic [31:0] w,
      logic [31:0] rdat, int gd, int rd, bit err, logic [31:0] maddr, logic [3:0] be,
      logic [31:0] mw, logic [31:0] data, int lat);
    vec_t v;
    v.ld = ld; v.st = st; v.code = code; v.addr = a; v.wdata = w; v.rdata = rdat;
    v.gd = gd; v.rd = rd; v.err = err; v.maddr = maddr; v.be = be; v.mwdata = mw;
    v.data = data; v.lat = lat;
    return v;
  endfunction

  // Reference: an access of `size` bytes at byte offset `off` must fit inside one word.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int size, off;
    bit sgn, ldc, stc;
    longint val;
    size = 0; sgn = 0; ldc = 0; stc = 0;
    case (v.code)
      LB:  begin size = 1; sgn = 1; ldc = 1; end
      LH:  begin size = 2; sgn = 1; ldc = 1; end
      LW:  begin size = 4; ldc = 1; end
      LBU: begin size = 1; ldc = 1; end
      LHU: begin size = 2; ldc = 1; end
      SB:  begin size = 1; stc = 1; end
      SH:  begin size = 2; stc = 1; end
      SW:  begin size = 4; stc = 1; end
      default: size = 0;
    endcase
    off = int'(v.addr % 4);
    v.err = (v.ld && v.st) || (v.ld && !ldc) || (v.st && !stc) || (off + size > 4) ||
            ({32'b0, v.addr} >= (64'd1 << (AW + 2)));
    v.maddr = (v.addr / 4) % (32'd1 << AW);
    v.be = 4'(((1 << size) - 1) << off);
    case (v.code)
      SB:      v.mwdata = v.wdata[7:0] * 32'h01010101;
      SH:      v.mwdata = (v.wdata % 65536) * (32'd1 << (8 * off));
      default: v.mwdata = v.wdata;
    endcase
    if (v.err || v.st) v.data = 0;
    else begin
      val = ({32'b0, v.rdata} >> (8 * off)) % (64'd1 << (8 * size));
      if (sgn && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
      v.data = val[31:0];
    end
    v.lat = v.err ? 1 : (v.st ? 2 + v.gd : 3 + v.gd);
    return v;
  endfunction

  task automatic start(bit ld, bit st, logic [5:0] code, logic [31:0] a, logic [31:0] w);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1; is_load = ld; is_store = st; alucode = code; addr = a; wdata = w;
    @(negedge clk);
    req_valid = 0; is_load = 1'($urandom); is_store = 1'($urandom);
    alucode = 6'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic run(input vec_t v);
    int cyc, waited, rcnt, rcyc;
    bit done, gprev, seen;
    start(v.ld, v.st, v.code, v.addr, v.wdata);
    cyc = 1; waited = 0; rcnt = 0; rcyc = 0; done = 0; gprev = 0; seen = 0;
    while (!done && cyc < 60) begin
      mem_rdata = gprev ? v.rdata : $urandom;
      gprev = 0; mem_gnt = 0;
      if (v.err) chk("err_no_mem_req", 32'(mem_req), 32'd0);
      if (mem_req) begin
        seen = 1;
        chk("mem_addr", 32'(mem_addr), v.maddr);
        chk("mem_be", 32'(mem_be), 32'(v.be));
        chk("mem_we", 32'(mem_we), 32'(v.st));
        if (v.st) chk("mem_wdata", mem_wdata, v.mwdata);
        if (waited >= v.gd) begin mem_gnt = 1; gprev = 1; end
        else waited++;
      end
      if (resp_valid) begin
        if (rcyc == 0) begin
          rcyc = cyc;
          chk("latency", 32'(cyc), 32'(v.lat));
        end
        chk("resp_data", resp_data, v.data);
        chk("resp_err", 32'(resp_err), 32'(v.err));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        if (rcnt >= v.rd) begin resp_ready = 1; done = 1; end
        else rcnt++;
      end
      @(negedge clk);
      resp_ready = 0; mem_gnt = 0;
      cyc++;
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: no response after %0d cycles", cyc);
    end
    if (!v.err) chk("mem_req_seen", 32'(seen), 32'd1);
    chk("resp_dropped", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[12];
  logic [5:0] codes[8];

  initial begin
    tbl[0]  = mk(0, 1, SB,  32'h103,   32'hAB,       0,            0, 0, 0, 32'h40,   4'b1000, 32'hABABABAB, 0, 2);
    tbl[1]  = mk(1, 0, LB,  32'h102,   0,            32'h00F00000, 0, 0, 0, 32'h40,   4'b0100, 0, 32'hFFFFFFF0, 3);
    tbl[2]  = mk(1, 0, LBU, 32'h102,   0,            32'h00F00000, 0, 0, 0, 32'h40,   4'b0100, 0, 32'h000000F0, 3);
    tbl[3]  = mk(1, 0, LW,  32'h6,     0,            0,            0, 0, 1, 0,        0,       0, 0, 1);
    tbl[4]  = mk(0, 1, SH,  32'h7,     32'h1234,     0,            0, 0, 1, 0,        0,       0, 0, 1);
    tbl[5]  = mk(1, 0, LH,  32'h21,    0,            32'h0080FF00, 0, 0, 0, 32'h8,    4'b0110, 0, 32'hFFFF80FF, 3);
    tbl[6]  = mk(0, 1, SW,  32'h20000, 32'h1,        0,            0, 0, 1, 0,        0,       0, 0, 1);
    tbl[7]  = mk(0, 1, SW,  32'h1FFFC, 32'h12345678, 0,            0, 0, 0, 32'h7FFF, 4'hF,    32'h12345678, 0, 2);
    tbl[8]  = mk(1, 0, LW,  32'h100,   0,            32'hDEADBEEF, 3, 0, 0, 32'h40,   4'hF,    0, 32'hDEADBEEF, 6);
    tbl[9]  = mk(0, 1, SH,  32'h202,   32'hFFFF5AA5, 0,            1, 2, 0, 32'h80,   4'b1100, 32'h5AA50000, 0, 3);
    tbl[10] = mk(1, 1, LW,  32'h0,     0,            0,            0, 0, 1, 0,        0,       0, 0, 1);
    tbl[11] = mk(1, 0, SW,  32'h10,    0,            0,            0, 1, 1, 0,        0,       0, 0, 1);
    codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    // Reset: outputs cleared and req_ready held low while rst_n is low.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) run(tbl[i]);

    // A valid cycle with no direction is ignored.
    req_valid = 1; is_load = 0; is_store = 0; alucode = LW; addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nodir_resp", 32'(resp_valid), 32'd0);
      chk("nodir_mem_req", 32'(mem_req), 32'd0);
      chk("nodir_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 0;

    // Reset while waiting for read data abandons the load.
    start(1, 0, LW, 32'h10, 0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; rst_n = 0; mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("wrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("wrst_resp_data", resp_data, 32'd0);
    chk("wrst_mem_req", 32'(mem_req), 32'd0);
    chk("wrst_mem_wdata", mem_wdata, 32'd0);
    chk("wrst_ready", 32'(req_ready), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("wrst_ready_back", 32'(req_ready), 32'd1);
    chk("wrst_no_resp", 32'(resp_valid), 32'd0);

    // Reset coinciding with a store grant must not write.
    start(0, 1, SW, 32'h40, 32'hCAFEF00D);
    mem_gnt = 1; rst_n = 0;
    #1;
    chk("gnt_rst_we", 32'(mem_we), 32'd0);
    chk("gnt_rst_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_gnt = 0; rst_n = 1;
    chk("gnt_rst_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("gnt_rst_ready", 32'(req_ready), 32'd1);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      int r;
      r = int'($urandom_range(0, 19));
      v.ld = (r == 0) || (r < 10); v.st = (r == 0) || (r >= 10);
      if ($urandom_range(0, 9) == 0) v.code = codes[$urandom_range(0, 7)];
      else if (v.ld) v.code = codes[$urandom_range(0, 4)];
      else v.code = codes[$urandom_range(5, 7)];
      v.addr = {15'b0, 15'($urandom), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) v.addr = v.addr | (32'd1 << $urandom_range(17, 31));
      v.wdata = $urandom; v.rdata = $urandom;
      v.gd = int'($urandom_range(0, 3)); v.rd = int'($urandom_range(0, 2));
      run(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
